// File: rtl/cam_pixel_capture.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cam_pixel_capture
//
// Purpose:
//   Front end of the camera/VGA pipeline. Pairs the OV7670 RGB565 byte stream
//   (QCIF, 176x144) into RGB444 pixels and drives the write port of the
//   12-bit x 15-bit camera frame buffer. While capturing, it counts how many
//   pixels inside the central inspection window have a clearly dominant
//   channel. At every frame end it publishes the winning colour as a 2-bit code.
//
// Ports:
//   Clock          in   1   camera pixel clock (PCLK), the only clock
//   Reset          in   1   synchronous, active-high reset
//   Href           in   1   line valid from the camera
//   Vsync          in   1   frame sync, high during vertical blanking
//   Data           in   8   camera byte bus
//   Pause          in   1   1 = hold off buffer writes (capture/classify go on)
//   PixelData      out  12  RGB444 pixel {R,G,B}
//   PixelAddr      out  15  frame buffer address, y*H_PIXELS + x
//   PixelWrite     out  1   one-cycle write strobe
//   FrameDone      out  1   one-cycle pulse at end of frame
//   PromedioColor  out  2   00 none, 01 red, 10 green, 11 blue
//
// Build option:
//   CAPTURE_TEST_PATTERN_EN - when defined, PixelData carries eight vertical
//   colour bars selected by x[7:5] instead of camera data. Timing, addressing,
//   Pause and classification behave exactly as with camera data.
// -----------------------------------------------------------------------------
module cam_pixel_capture #(
  parameter int H_PIXELS   = 176,
  parameter int V_LINES    = 144,
  parameter int WIN_X0     = 37,
  parameter int WIN_X1     = 138,
  parameter int WIN_Y0     = 21,
  parameter int WIN_Y1     = 104,
  parameter int DOM_MARGIN = 2,
  parameter int MIN_COUNT  = 256
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Href,
  input  logic        Vsync,
  input  logic [7:0]  Data,
  input  logic        Pause,
  output logic [11:0] PixelData,
  output logic [14:0] PixelAddr,
  output logic        PixelWrite,
  output logic        FrameDone,
  output logic [1:0]  PromedioColor
);

  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam int CW = 14;

  localparam logic [XW-1:0] X_LIMIT    = XW'(H_PIXELS);
  localparam logic [YW-1:0] Y_LIMIT    = YW'(V_LINES);
  localparam logic [XW-1:0] WIN_X_LO   = XW'(WIN_X0);
  localparam logic [XW-1:0] WIN_X_HI   = XW'(WIN_X1);
  localparam logic [YW-1:0] WIN_Y_LO   = YW'(WIN_Y0);
  localparam logic [YW-1:0] WIN_Y_HI   = YW'(WIN_Y1);
  localparam logic [4:0]    MARGIN5    = 5'(DOM_MARGIN);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] MIN_CNT    = CW'(MIN_COUNT);
  localparam logic [14:0]   ROW_STRIDE = 15'(H_PIXELS);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    IDLE       = 2'd1,
    BYTE1      = 2'd2,  // first byte held, waiting for the second
    BYTE0      = 2'd3   // pixel just completed, next byte is a first byte
  } stateT;

  stateT stateReg, stateNext;

  // Href, Vsync and Data share one register stage so that the byte seen
  // by the state machine is always the one that arrived with that Href.
  logic        hrefReg, hrefPrev;
  logic        vsyncReg, vsyncPrev;
  logic [7:0]  dataReg;
  logic [7:0]  firstByteReg;
  logic [XW-1:0] xReg;
  logic [YW-1:0] yReg;

  logic vsyncRise, vsyncFall, hrefFall;
  logic latchFirst, pixelDone, posClear, lineEnd, frameEnd;
  logic inFrame, inWindow, countEn;

  logic [11:0] camRgb, pixRgb;
  logic [3:0]  pixR, pixG, pixB;
  logic [2:0]  domVec;
  logic [14:0] addrCalc;
  logic [CW-1:0] chanCount [3];
  logic [1:0]  colourCode;

  // ---------------------------------------------------------------------------
  // Sync edge detection
  // ---------------------------------------------------------------------------
  assign vsyncRise = vsyncReg  & ~vsyncPrev;
  assign vsyncFall = ~vsyncReg & vsyncPrev;
  assign hrefFall  = ~hrefReg  & hrefPrev;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateReg <= WAIT_FRAME;
    end else begin
      stateReg <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. A Vsync rise aborts whatever is in progress.
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = stateReg;
    if (vsyncRise) begin
      stateNext = WAIT_FRAME;
    end else begin
      case (stateReg)
        WAIT_FRAME: if (vsyncFall) stateNext = IDLE;
        IDLE:       if (hrefReg) stateNext = BYTE1;
        BYTE1:      stateNext = hrefReg ? BYTE0 : IDLE;  // Href low drops an unpaired byte
        BYTE0:      stateNext = hrefReg ? BYTE1 : IDLE;
        default:    stateNext = WAIT_FRAME;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    latchFirst = 1'b0;
    pixelDone  = 1'b0;
    posClear   = 1'b0;
    lineEnd    = 1'b0;
    if (!vsyncRise) begin
      case (stateReg)
        WAIT_FRAME:  posClear   = vsyncFall;
        IDLE, BYTE0: latchFirst = hrefReg;
        BYTE1:       pixelDone  = hrefReg;
        default:     latchFirst = 1'b0;
      endcase
      lineEnd = hrefFall && (stateReg != WAIT_FRAME);
    end
  end

  // A frame only counts as finished if at least one line was closed.
  assign frameEnd = vsyncRise && (yReg != '0);

  // ---------------------------------------------------------------------------
  // Pixel formation
  // ---------------------------------------------------------------------------
  // b1 = RRRRRGGG, b2 = GGGBBBBB; keep the top 4 bits of each channel.
  assign camRgb = {firstByteReg[7:4], firstByteReg[2:0], dataReg[7], dataReg[4:1]};

`ifdef CAPTURE_TEST_PATTERN_EN
  logic [7:0]  barX;
  logic [11:0] barRgb;

  assign barX = 8'(xReg);

  always_comb begin
    case (barX[7:5])
      3'd0:    barRgb = 12'h000;
      3'd1:    barRgb = 12'hF00;
      3'd2:    barRgb = 12'h0F0;
      3'd3:    barRgb = 12'h00F;
      3'd4:    barRgb = 12'hFF0;
      3'd5:    barRgb = 12'h0FF;
      3'd6:    barRgb = 12'hF0F;
      default: barRgb = 12'hFFF;
    endcase
  end

  assign pixRgb = barRgb;
`else
  assign pixRgb = camRgb;
`endif

  assign pixR = pixRgb[11:8];
  assign pixG = pixRgb[7:4];
  assign pixB = pixRgb[3:0];

  assign inFrame  = (xReg < X_LIMIT) && (yReg < Y_LIMIT);
  assign inWindow = (xReg >= WIN_X_LO) && (xReg <= WIN_X_HI) &&
                    (yReg >= WIN_Y_LO) && (yReg <= WIN_Y_HI);
  assign countEn  = pixelDone && inWindow;

  // Only evaluated while x and y are inside the frame, so it stays <= 25343.
  always_comb begin
    addrCalc = 15'(yReg) * ROW_STRIDE + 15'(xReg);
  end

  // Dominance: channel >= other + margin, done in 5 bits so 15+2 cannot wrap.
  always_comb begin
    logic [4:0] r5, g5, b5;
    r5 = {1'b0, pixR};
    g5 = {1'b0, pixG};
    b5 = {1'b0, pixB};
    domVec[0] = (r5 >= g5 + MARGIN5) && (r5 >= b5 + MARGIN5);
    domVec[1] = (g5 >= r5 + MARGIN5) && (g5 >= b5 + MARGIN5);
    domVec[2] = (b5 >= r5 + MARGIN5) && (b5 >= g5 + MARGIN5);
  end

  // ---------------------------------------------------------------------------
  // Capture datapath and buffer write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hrefReg       <= 1'b0;
      hrefPrev      <= 1'b0;
      vsyncReg      <= 1'b0;
      vsyncPrev     <= 1'b0;
      dataReg       <= '0;
      firstByteReg  <= '0;
      xReg          <= '0;
      yReg          <= '0;
      PixelWrite    <= 1'b0;
      PixelData     <= '0;
      PixelAddr     <= '0;
      FrameDone     <= 1'b0;
      PromedioColor <= 2'b00;
    end else begin
      hrefReg   <= Href;
      hrefPrev  <= hrefReg;
      vsyncReg  <= Vsync;
      vsyncPrev <= vsyncReg;
      dataReg   <= Data;

      PixelWrite <= 1'b0;
      FrameDone  <= 1'b0;

      if (latchFirst) begin
        firstByteReg <= dataReg;
      end

      if (posClear) begin
        xReg <= '0;
        yReg <= '0;
      end else if (lineEnd) begin
        // Empty lines (x still 0) do not advance y.
        if (xReg != '0) begin
          xReg <= '0;
          if (yReg != Y_LIMIT) begin
            yReg <= yReg + 1'b1;
          end
        end
      end else if (pixelDone) begin
        if (inFrame) begin
          PixelWrite <= !Pause;
          PixelData  <= pixRgb;
          PixelAddr  <= addrCalc;
        end
        if (xReg != X_LIMIT) begin
          xReg <= xReg + 1'b1;
        end
      end

      if (frameEnd) begin
        FrameDone     <= 1'b1;
        PromedioColor <= colourCode;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel dominance counters (0 = R, 1 = G, 2 = B). They clear on the
  // cycle after the frame result is published.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gChanCount
      logic [CW-1:0] countReg;

      always_ff @(posedge Clock) begin
        if (Reset || FrameDone) begin
          countReg <= '0;
        end else if (countEn && domVec[gi] && (countReg != CNT_MAX)) begin
          countReg <= countReg + 1'b1;
        end
      end

      assign chanCount[gi] = countReg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Frame result: largest count wins, ties go R then G then B.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [CW-1:0] best;
    if ((chanCount[0] >= chanCount[1]) && (chanCount[0] >= chanCount[2])) begin
      best       = chanCount[0];
      colourCode = 2'b01;
    end else if (chanCount[1] >= chanCount[2]) begin
      best       = chanCount[1];
      colourCode = 2'b10;
    end else begin
      best       = chanCount[2];
      colourCode = 2'b11;
    end
    if (best < MIN_CNT) begin
      colourCode = 2'b00;
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cam_pixel_capture
//
// Directed bench for cam_pixel_capture. Inputs change on the falling clock
// edge; outputs are logged on the falling edge by a small monitor and
// checked by each scenario task against hand-computed values.
// -----------------------------------------------------------------------------
module tb_cam_pixel_capture;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Href;
  logic        Vsync;
  logic [7:0]  Data;
  logic        Pause;
  logic [11:0] PixelData;
  logic [14:0] PixelAddr;
  logic        PixelWrite;
  logic        FrameDone;
  logic [1:0]  PromedioColor;

  int vectors     = 0;
  int miscompares = 0;

  logic [14:0] wrAddrQ [$];
  logic [11:0] wrDataQ [$];
  int          fdCount  = 0;
  logic [1:0]  pcAtDone = 2'bxx;

  always #5 Clock = ~Clock;

  cam_pixel_capture dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Href          (Href),
    .Vsync         (Vsync),
    .Data          (Data),
    .Pause         (Pause),
    .PixelData     (PixelData),
    .PixelAddr     (PixelAddr),
    .PixelWrite    (PixelWrite),
    .FrameDone     (FrameDone),
    .PromedioColor (PromedioColor)
  );

  // Log write-port traffic and frame pulses.
  always @(negedge Clock) begin
    if (PixelWrite === 1'b1) begin
      wrAddrQ.push_back(PixelAddr);
      wrDataQ.push_back(PixelData);
    end
    if (FrameDone === 1'b1) begin
      fdCount  = fdCount + 1;
      pcAtDone = PromedioColor;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic h, input logic v, input logic [7:0] d);
    @(negedge Clock);
    Href  = h;
    Vsync = v;
    Data  = d;
  endtask

  task automatic clearStats();
    wrAddrQ.delete();
    wrDataQ.delete();
    fdCount  = 0;
    pcAtDone = 2'bxx;
  endtask

  task automatic startFrame();
    repeat (4) drive(1'b0, 1'b1, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic endFrame();
    repeat (5) drive(1'b0, 1'b1, 8'h00);
  endtask

  task automatic sendLine(input int nPix, input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < nPix; i++) begin
      drive(1'b1, 1'b0, b1);
      drive(1'b1, 1'b0, b2);
    end
    repeat (2) drive(1'b0, 1'b0, 8'h00);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    Reset = 1'b1; Href = 1'b0; Vsync = 1'b0; Data = 8'h00; Pause = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    vectors++; if (PixelWrite !== 1'b0) begin miscompares++; $display("FAIL reset PixelWrite: got %b, want 0", PixelWrite); end
    vectors++; if (PixelData !== 12'h000) begin miscompares++; $display("FAIL reset PixelData: got %h, want 000", PixelData); end
    vectors++; if (PixelAddr !== 15'd0) begin miscompares++; $display("FAIL reset PixelAddr: got %0d, want 0", PixelAddr); end
    vectors++; if (FrameDone !== 1'b0) begin miscompares++; $display("FAIL reset FrameDone: got %b, want 0", FrameDone); end
    vectors++; if (PromedioColor !== 2'b00) begin miscompares++; $display("FAIL reset PromedioColor: got %b, want 00", PromedioColor); end
    Reset = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    $display("test_reset done");
  endtask

  // 144 lines of 180 pixels then 6 extra short lines: everything beyond
  // 176x144 must be dropped, leaving exactly one full frame of red.
  task automatic test_full_frame();
    int bad;
    int breaks;
    int maxAddr;
    logic [14:0] firstAddr;
    logic [14:0] lastAddr;
    clearStats();
    startFrame();
    for (int y = 0; y < 150; y++) begin
      sendLine((y < 144) ? 180 : 4, 8'hF8, 8'h00);
    end
    endFrame();
    bad = 0; breaks = 0; maxAddr = 0;
    foreach (wrDataQ[i]) if (wrDataQ[i] !== 12'hF00) bad++;
    foreach (wrAddrQ[i]) if (int'(wrAddrQ[i]) > maxAddr) maxAddr = int'(wrAddrQ[i]);
    for (int i = 1; i < wrAddrQ.size(); i++) if (int'(wrAddrQ[i]) !== int'(wrAddrQ[i-1]) + 1) breaks++;
    firstAddr = (wrAddrQ.size() > 0) ? wrAddrQ[0] : 15'bx;
    lastAddr  = (wrAddrQ.size() > 0) ? wrAddrQ[wrAddrQ.size()-1] : 15'bx;
    vectors++; if (wrAddrQ.size() !== 25344) begin miscompares++; $display("FAIL full_frame writes: got %0d, want 25344", wrAddrQ.size()); end
    vectors++; if (firstAddr !== 15'd0) begin miscompares++; $display("FAIL full_frame first addr: got %0d, want 0", firstAddr); end
    vectors++; if (lastAddr !== 15'd25343) begin miscompares++; $display("FAIL full_frame last addr: got %0d, want 25343", lastAddr); end
    vectors++; if (maxAddr !== 25343) begin miscompares++; $display("FAIL full_frame max addr: got %0d, want 25343", maxAddr); end
    vectors++; if (breaks !== 0) begin miscompares++; $display("FAIL full_frame addr sequence breaks: got %0d, want 0", breaks); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL full_frame data not F00: got %0d, want 0", bad); end
    vectors++; if (fdCount !== 1) begin miscompares++; $display("FAIL full_frame FrameDone cycles: got %0d, want 1", fdCount); end
    vectors++; if (pcAtDone !== 2'b01) begin miscompares++; $display("FAIL full_frame PromedioColor: got %b, want 01", pcAtDone); end
    $display("test_full_frame: %0d writes, last addr %0d", wrAddrQ.size(), lastAddr);
  endtask

  // Grey window gives no dominant counts; the frame ends with Vsync rising
  // while the second byte of a pixel is on the bus, so that pixel is lost.
  task automatic test_grey_and_abort();
    int bad;
    logic [14:0] lastAddr;
    clearStats();
    startFrame();
    for (int y = 0; y < 22; y++) sendLine(176, 8'h84, 8'h10);
    drive(1'b1, 1'b0, 8'h84);
    drive(1'b1, 1'b0, 8'h10);
    drive(1'b1, 1'b0, 8'h84);
    drive(1'b1, 1'b1, 8'h10);
    endFrame();
    bad = 0;
    foreach (wrDataQ[i]) if (wrDataQ[i] !== 12'h888) bad++;
    lastAddr = (wrAddrQ.size() > 0) ? wrAddrQ[wrAddrQ.size()-1] : 15'bx;
    vectors++; if (wrAddrQ.size() !== 3873) begin miscompares++; $display("FAIL grey writes: got %0d, want 3873", wrAddrQ.size()); end
    vectors++; if (lastAddr !== 15'd3872) begin miscompares++; $display("FAIL grey last addr: got %0d, want 3872", lastAddr); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL grey data not 888: got %0d, want 0", bad); end
    vectors++; if (fdCount !== 1) begin miscompares++; $display("FAIL grey FrameDone cycles: got %0d, want 1", fdCount); end
    vectors++; if (pcAtDone !== 2'b00) begin miscompares++; $display("FAIL grey PromedioColor: got %b, want 00", pcAtDone); end
    $display("test_grey_and_abort: %0d writes, colour %b", wrAddrQ.size(), pcAtDone);
  endtask

  // Seven bytes on line 0 (last one unpaired), then a normal line 1.
  task automatic test_odd_bytes();
    logic [14:0] expAddr [5];
    logic [11:0] expData [5];
    expAddr[0] = 15'd0;   expData[0] = 12'h00F;
    expAddr[1] = 15'd1;   expData[1] = 12'h888;
    expAddr[2] = 15'd2;   expData[2] = 12'hF00;
    expAddr[3] = 15'd176; expData[3] = 12'hF00;
    expAddr[4] = 15'd177; expData[4] = 12'h0F0;
    clearStats();
    startFrame();
    drive(1'b1, 1'b0, 8'h00); drive(1'b1, 1'b0, 8'h1F);
    drive(1'b1, 1'b0, 8'h84); drive(1'b1, 1'b0, 8'h10);
    drive(1'b1, 1'b0, 8'hF8); drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h07);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'hF8); drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h07); drive(1'b1, 1'b0, 8'h80);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    endFrame();
    vectors++; if (wrAddrQ.size() !== 5) begin miscompares++; $display("FAIL odd writes: got %0d, want 5", wrAddrQ.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < wrAddrQ.size()) begin
        vectors++; if (wrAddrQ[i] !== expAddr[i]) begin miscompares++; $display("FAIL odd write %0d addr: got %0d, want %0d", i, wrAddrQ[i], expAddr[i]); end
        vectors++; if (wrDataQ[i] !== expData[i]) begin miscompares++; $display("FAIL odd write %0d data: got %h, want %h", i, wrDataQ[i], expData[i]); end
      end
    end
    vectors++; if (fdCount !== 1) begin miscompares++; $display("FAIL odd FrameDone cycles: got %0d, want 1", fdCount); end
    vectors++; if (pcAtDone !== 2'b00) begin miscompares++; $display("FAIL odd PromedioColor: got %b, want 00", pcAtDone); end
    $display("test_odd_bytes: %0d writes", wrAddrQ.size());
  endtask

  // 24 lines of blue with Pause held: window rows 21..23 give 306 blue counts.
  task automatic test_pause_blue();
    clearStats();
    Pause = 1'b1;
    startFrame();
    for (int y = 0; y < 24; y++) sendLine(176, 8'h00, 8'h1F);
    endFrame();
    Pause = 1'b0;
    vectors++; if (wrAddrQ.size() !== 0) begin miscompares++; $display("FAIL pause writes: got %0d, want 0", wrAddrQ.size()); end
    vectors++; if (fdCount !== 1) begin miscompares++; $display("FAIL pause FrameDone cycles: got %0d, want 1", fdCount); end
    vectors++; if (pcAtDone !== 2'b11) begin miscompares++; $display("FAIL pause PromedioColor: got %b, want 11", pcAtDone); end
    vectors++; if (PromedioColor !== 2'b11) begin miscompares++; $display("FAIL pause PromedioColor hold: got %b, want 11", PromedioColor); end
    $display("test_pause_blue: colour %b", pcAtDone);
  endtask

  // Reset for 3 cycles in the middle of an active line.
  task automatic test_reset_midline();
    clearStats();
    startFrame();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'hF8);
      drive(1'b1, 1'b0, 8'h00);
    end
    Reset = 1'b1;
    repeat (3) drive(1'b1, 1'b0, 8'hF8);
    vectors++; if (PixelWrite !== 1'b0) begin miscompares++; $display("FAIL midreset PixelWrite: got %b, want 0", PixelWrite); end
    vectors++; if (PixelData !== 12'h000) begin miscompares++; $display("FAIL midreset PixelData: got %h, want 000", PixelData); end
    vectors++; if (PixelAddr !== 15'd0) begin miscompares++; $display("FAIL midreset PixelAddr: got %0d, want 0", PixelAddr); end
    vectors++; if (FrameDone !== 1'b0) begin miscompares++; $display("FAIL midreset FrameDone: got %b, want 0", FrameDone); end
    vectors++; if (PromedioColor !== 2'b00) begin miscompares++; $display("FAIL midreset PromedioColor: got %b, want 00", PromedioColor); end
    Reset = 1'b0;
    clearStats();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 8'hF8);
    end
    repeat (5) drive(1'b0, 1'b0, 8'h00);
    vectors++; if (wrAddrQ.size() !== 0) begin miscompares++; $display("FAIL midreset writes before Vsync: got %0d, want 0", wrAddrQ.size()); end
    startFrame();
    sendLine(2, 8'hF8, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    vectors++; if (fdCount !== 0) begin miscompares++; $display("FAIL midreset FrameDone on y=0 Vsync: got %0d, want 0", fdCount); end
    vectors++; if (wrAddrQ.size() !== 2) begin miscompares++; $display("FAIL midreset writes after Vsync: got %0d, want 2", wrAddrQ.size()); end
    if (wrAddrQ.size() >= 2) begin
      vectors++; if (wrAddrQ[0] !== 15'd0) begin miscompares++; $display("FAIL midreset addr0: got %0d, want 0", wrAddrQ[0]); end
      vectors++; if (wrAddrQ[1] !== 15'd1) begin miscompares++; $display("FAIL midreset addr1: got %0d, want 1", wrAddrQ[1]); end
    end
    $display("test_reset_midline: %0d writes after new frame", wrAddrQ.size());
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_grey_and_abort();
    test_odd_bytes();
    test_pause_blue();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Upstream stage of the camera/VGA top level.
- Deserialises the OV7670 RGB565 byte stream (QCIF 176x144) into RGB444 pixels and produces the write port of the 12-bit x 15-bit camera frame buffer.
- Classifies the dominant colour inside the central inspection window once per frame and drives the 2-bit PromedioColor code consumed by the display stage.

Parameters:
- H_PIXELS, 176, active pixels per line; pixels beyond this are dropped.
- V_LINES, 144, active lines per frame; lines beyond this are dropped.
- WIN_X0, 37, first x column of the inspection window, inclusive.
- WIN_X1, 138, last x column of the inspection window, inclusive.
- WIN_Y0, 21, first y row of the inspection window, inclusive.
- WIN_Y1, 104, last y row of the inspection window, inclusive.
- DOM_MARGIN, 2, amount by which a 4-bit channel must exceed both other channels to be counted as dominant.
- MIN_COUNT, 256, minimum winning count required for a non-zero colour code.

Ports:
- Clock  in  1  camera pixel clock (PCLK); the only clock.
- Reset  in  1  synchronous, active-high reset.
- Href  in  1  line-valid from the camera.
- Vsync  in  1  frame sync from the camera; high = vertical blanking.
- Data  in  8  camera byte bus.
- Pause  in  1  1 = suppress buffer writes; capture and classification continue.
- PixelData  out  12  RGB444 pixel, {R,G,B}.
- PixelAddr  out  15  frame buffer address, y*H_PIXELS+x.
- PixelWrite  out  1  one-cycle write strobe.
- FrameDone  out  1  one-cycle pulse at end of frame.
- PromedioColor  out  2  00 none, 01 red, 10 green, 11 blue.

Behaviour:
- Reset values: all outputs 0, state WAIT_FRAME, x=y=0, all accumulators 0. Reset has priority over every other event.
- Vsync and Href are registered once. Edge detection uses the registered and previous registered values.
- State machine:
  - WAIT_FRAME -> IDLE on Vsync falling edge; x and y cleared.
  - IDLE -> BYTE1 on registered Href=1; the first byte is latched on that same cycle.
  - BYTE1 -> BYTE0 on the next cycle, where the second byte is latched. On this cycle the pixel completes and PixelWrite asserts (see pixel rule).
  - BYTE0 -> BYTE1 while Href=1.
  - Href falling edge returns the machine to IDLE and discards any unpaired first byte.
  - Vsync rising edge in any state returns the machine to WAIT_FRAME and discards any partial pixel.
- Pixel conversion:
  - First byte b1 = RRRRRGGG, second byte b2 = GGGBBBBB.
  - R=b1[7:4], G={b1[2:0],b2[7]}, B=b2[4:1].
- Pixel write rule:
  - When the second byte is latched and x<H_PIXELS and y<V_LINES, PixelWrite=!Pause on the following cycle.
  - PixelData and PixelAddr are valid in the same cycle as PixelWrite.
  - PixelAddr max = 25343; it never wraps.
  - x increments per completed pixel and saturates at H_PIXELS.
- Line handling: on Href falling edge, if x>0 then y increments (saturating at V_LINES) and x is cleared.
- Classification, applied per completed pixel inside the window (WIN_X0<=x<=WIN_X1, WIN_Y0<=y<=WIN_Y1):
  - A channel is dominant if it is >= each of the other two channels plus DOM_MARGIN, compared in 5-bit unsigned arithmetic.
  - The dominant channel's 14-bit counter increments and saturates at 16383.
  - Pause does not affect counting.
- Frame end (Vsync rising edge with y>0):
  - FrameDone=1 for exactly one cycle.
  - PromedioColor updates on that same cycle to the channel with the largest count; ties resolve R>G>B.
  - PromedioColor=00 if the largest count < MIN_COUNT.
  - The counters clear on the next cycle.
  - A Vsync rising edge with y=0 produces no pulse and no update.
- PromedioColor holds its value between frames.

Optional Feature:
- Macro: CAPTURE_TEST_PATTERN_EN.
- Defined:
  - PixelData is replaced by colour bars: x[7:5] indexes 8 bars black, red F00, green 0F0, blue 00F, yellow FF0, cyan 0FF, magenta F0F, white FFF.
  - Timing, addressing and Pause are unchanged.
  - Classification uses the bar pixels.
- Undefined: camera data is used and no pattern logic is synthesised.

Test Plan:
- Reset held 3 cycles mid-line -> all outputs 0; the next write occurs only after a new Vsync falling edge.
- One frame of 144 lines x 176 pixels, bytes b1=F8 b2=00 -> 25344 writes, PixelData=F00, last PixelAddr=25343, FrameDone one pulse, PromedioColor=01.
- Line of 180 pixels and frame of 150 lines -> no writes with x>=176 or y>=144; PixelAddr never exceeds 25343.
- Href drops after an odd byte count (7 bytes) -> 3 writes; next line begins at x=0 of y+1 with correct byte pairing.
- Pause=1 for a full frame of pure blue (b1=00 b2=1F) -> PixelWrite never asserts, FrameDone pulses, PromedioColor=11.
- Window of grey pixels (b1=84 b2=10, R=G=B=8) -> no counts; PromedioColor=00 at FrameDone. Then a Vsync rise mid-pixel -> partial pixel discarded, no write.
